// File: rtl/serial_defs.sv
// Shared definitions for the serial byte assembler.
// State encodings are also used by the bench.
package serial_defs;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    HOLD  = 2'd2
  } state_t;

endpackage

// File: rtl/shift_reg_sipo.sv
// Serial-in parallel-out shift register.
// MSB_FIRST picks the shift direction.
module shift_reg_sipo #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             Clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             shift_en,
  input  logic             din,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge Clk) begin
    if (reset || clr) begin
      q <= '0;
    end else if (shift_en) begin
      if (MSB_FIRST)
        q <= {q[WIDTH-2:0], din};
      else
        q <= {din, q[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/serial_byte_assembler.sv
// Assembles a serial bit stream into WIDTH-bit words
// and holds each word until the consumer takes it.
module serial_byte_assembler
  import serial_defs::*;
#(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1,
  localparam int CW       = $clog2(WIDTH) + 1
) (
  input  logic             Clk,
  input  logic             reset,
  input  logic             start,
  input  logic             bit_valid,
  input  logic             bit_in,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             busy,
  output logic             overrun,
  output logic [CW-1:0]    bit_count
);

  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] FULL = CW'(WIDTH);

  state_t           state;
  logic [WIDTH-1:0] sr_q;
  logic [WIDTH-1:0] word;
  logic             sr_clr;
  logic             sr_en;

  assign sr_clr = start && (state != HOLD);
  assign sr_en  = (state == SHIFT) && bit_valid && !start;

  // The completed word includes the bit sampled on this edge.
  assign word = MSB_FIRST ? {sr_q[WIDTH-2:0], bit_in}
                          : {bit_in, sr_q[WIDTH-1:1]};

  shift_reg_sipo #(
    .WIDTH    (WIDTH),
    .MSB_FIRST(MSB_FIRST)
  ) u_sr (
    .Clk     (Clk),
    .reset   (reset),
    .clr     (sr_clr),
    .shift_en(sr_en),
    .din     (bit_in),
    .q       (sr_q)
  );

  always_ff @(posedge Clk) begin
    if (reset) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      out_data  <= '0;
      busy      <= 1'b0;
      overrun   <= 1'b0;
      bit_count <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            state     <= SHIFT;
            busy      <= 1'b1;
            bit_count <= '0;
          end
        end
        SHIFT: begin
          if (start) begin
            bit_count <= '0;
          end else if (bit_valid) begin
            if (bit_count == LAST) begin
              out_data  <= word;
              out_valid <= 1'b1;
              bit_count <= FULL;
              busy      <= 1'b0;
              state     <= HOLD;
            end else begin
              bit_count <= bit_count + CW'(1);
            end
          end
        end
        HOLD: begin
          if (bit_valid)
            overrun <= 1'b1;
          if (out_ready) begin
            out_valid <= 1'b0;
            bit_count <= '0;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
          busy      <= 1'b0;
          bit_count <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_byte_assembler.sv
// Directed bench: MSB-first and LSB-first instances
// share one stimulus stream.
module tb_serial_byte_assembler;
  import serial_defs::*;

  logic       Clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic       bit_valid = 1'b0;
  logic       bit_in = 1'b0;
  logic       out_ready = 1'b0;

  logic       m_valid, l_valid;
  logic [7:0] m_data, l_data;
  logic       m_busy, l_busy;
  logic       m_ovr, l_ovr;
  logic [3:0] m_cnt, l_cnt;

  int checks = 0;
  int errors = 0;

  serial_byte_assembler #(.WIDTH(8), .MSB_FIRST(1'b1)) u_msb (
    .Clk(Clk), .reset(reset), .start(start),
    .bit_valid(bit_valid), .bit_in(bit_in),
    .out_ready(out_ready), .out_valid(m_valid),
    .out_data(m_data), .busy(m_busy),
    .overrun(m_ovr), .bit_count(m_cnt)
  );

  serial_byte_assembler #(.WIDTH(8), .MSB_FIRST(1'b0)) u_lsb (
    .Clk(Clk), .reset(reset), .start(start),
    .bit_valid(bit_valid), .bit_in(bit_in),
    .out_ready(out_ready), .out_valid(l_valid),
    .out_data(l_data), .busy(l_busy),
    .overrun(l_ovr), .bit_count(l_cnt)
  );

  always #5 Clk = ~Clk;

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic send(input logic b);
    bit_in = b;
    bit_valid = 1'b1;
    tick();
    bit_valid = 1'b0;
  endtask

  logic [7:0] s1 = 8'b1011_0010;
  logic [7:0] s2 = 8'hA5;

  initial begin
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    chk("rst_valid", 32'(m_valid), 32'd0);
    chk("rst_data", 32'(m_data), 32'd0);
    chk("rst_busy", 32'(m_busy), 32'd0);
    chk("rst_ovr", 32'(m_ovr), 32'd0);
    chk("rst_cnt", 32'(m_cnt), 32'd0);
    chk("rst_state", 32'(u_msb.state), 32'(IDLE));

    // frame 1: B2 msb-first, 4D lsb-first
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("f1_busy", 32'(m_busy), 32'd1);
    chk("f1_cnt0", 32'(m_cnt), 32'd0);
    for (int i = 7; i >= 0; i--) begin
      if (i == 4) chk("f1_cnt3", 32'(m_cnt), 32'd3);
      send(s1[i]);
      if (i > 0) chk("f1_novalid", 32'(m_valid), 32'd0);
    end
    chk("f1_valid", 32'(m_valid), 32'd1);
    chk("f1_msb", 32'(m_data), 32'hB2);
    chk("f1_lsb", 32'(l_data), 32'h4D);
    chk("f1_cnt8", 32'(m_cnt), 32'd8);
    chk("f1_busy0", 32'(m_busy), 32'd0);
    chk("f1_state", 32'(u_msb.state), 32'(HOLD));

    // stall in HOLD with incoming bits
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      bit_in = i[0];
      bit_valid = i[0] ? 1'b0 : 1'b1;
      start = (i == 2);
      tick();
      chk("hold_data", 32'(m_data), 32'hB2);
      chk("hold_valid", 32'(m_valid), 32'd1);
    end
    bit_valid = 1'b0;
    start = 1'b0;
    chk("hold_ovr", 32'(m_ovr), 32'd1);
    chk("hold_lsb", 32'(l_data), 32'h4D);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("xfer_valid", 32'(m_valid), 32'd0);
    chk("xfer_ovr", 32'(m_ovr), 32'd1);
    chk("xfer_cnt", 32'(m_cnt), 32'd0);
    chk("xfer_state", 32'(u_msb.state), 32'(IDLE));

    // restart mid-frame, start beats bit_valid
    start = 1'b1;
    tick();
    start = 1'b0;
    send(1'b1);
    send(1'b1);
    send(1'b1);
    chk("rs_cnt3", 32'(m_cnt), 32'd3);
    start = 1'b1;
    bit_valid = 1'b1;
    bit_in = 1'b1;
    tick();
    start = 1'b0;
    bit_valid = 1'b0;
    chk("rs_cnt0", 32'(m_cnt), 32'd0);
    chk("rs_busy", 32'(m_busy), 32'd1);
    for (int i = 7; i >= 0; i--) begin
      send(s2[i]);
      if (i > 0) begin
        tick();
        tick();
      end
    end
    chk("a5_valid", 32'(m_valid), 32'd1);
    chk("a5_msb", 32'(m_data), 32'hA5);
    chk("a5_lsb", 32'(l_data), 32'hA5);
    chk("a5_cnt", 32'(m_cnt), 32'd8);
    chk("a5_ovr", 32'(m_ovr), 32'd1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("a5_xfer", 32'(m_valid), 32'd0);

    // reset mid-frame
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 5; i++) send(1'b1);
    chk("mr_cnt5", 32'(m_cnt), 32'd5);
    reset = 1'b1;
    bit_valid = 1'b1;
    tick();
    reset = 1'b0;
    bit_valid = 1'b0;
    chk("mr_cnt", 32'(m_cnt), 32'd0);
    chk("mr_busy", 32'(m_busy), 32'd0);
    chk("mr_ovr", 32'(m_ovr), 32'd0);
    chk("mr_data", 32'(m_data), 32'd0);
    chk("mr_valid", 32'(m_valid), 32'd0);
    chk("mr_state", 32'(u_msb.state), 32'(IDLE));
    chk("mr_sr", 32'(u_msb.sr_q), 32'd0);
    for (int i = 0; i < 3; i++) send(1'b1);
    chk("idle_cnt", 32'(m_cnt), 32'd0);
    chk("idle_busy", 32'(m_busy), 32'd0);
    chk("idle_state", 32'(u_msb.state), 32'(IDLE));
    chk("idle_sr", 32'(u_msb.sr_q), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/serial_byte_assembler.md
SERIAL_BYTE_ASSEMBLER -- requirements
Module: serial_byte_assembler

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: Clk (all state on its rising edge) and reset (sampled only on that edge).
REQ-002 Parameter WIDTH SHALL default to 8 and set the assembled word width; legal range 2..32.
REQ-003 Parameter MSB_FIRST SHALL default to 1: 1 = first received bit lands in out_data[WIDTH-1]; 0 = first bit lands in out_data[0].
REQ-004 Port Clk SHALL be input, 1 bit: system clock.
REQ-005 Port reset SHALL be input, 1 bit: synchronous active-high reset.
REQ-006 Port start SHALL be input, 1 bit: begin a new frame.
REQ-007 Port bit_valid SHALL be input, 1 bit: bit_in is valid this cycle.
REQ-008 Port bit_in SHALL be input, 1 bit: serial data bit.
REQ-009 Port out_ready SHALL be input, 1 bit: the downstream register accepts out_data.
REQ-010 Port out_valid SHALL be output, 1 bit: out_data holds a complete word.
REQ-011 Port out_data SHALL be output, WIDTH bits: the assembled word.
REQ-012 Port busy SHALL be output, 1 bit: a frame is being shifted.
REQ-013 Port overrun SHALL be output, 1 bit: sticky flag for a dropped bit.
REQ-014 Port bit_count SHALL be output, $clog2(WIDTH)+1 bits: the number of bits received in the current frame.

Function
REQ-015 The FSM SHALL have three states, IDLE, SHIFT and HOLD, and a registered state register.
REQ-016 In IDLE: start=1 -> SHIFT with bit_count=0; bit_valid is ignored; busy=0.
REQ-017 In SHIFT: each bit_valid=1 cycle shifts bit_in into the internal shift register and increments bit_count; cycles with bit_valid=0 leave the state unchanged (gaps allowed); busy=1.
REQ-018 When bit_valid=1 and bit_count=WIDTH-1 in SHIFT, then on that edge: out_data <= the completed word, out_valid <= 1, bit_count <= WIDTH, state -> HOLD. Latency: out_valid is high in the cycle right after the edge that samples the last bit.
REQ-019 start=1 in SHIFT SHALL restart the frame: partial data is discarded, bit_count <= 0, state stays SHIFT; if bit_valid=1 in the same cycle, start wins and the bit is discarded.
REQ-020 In HOLD: out_valid=1 and out_data stable until a transfer (out_valid & out_ready at a rising edge); on transfer, out_valid <= 0, bit_count <= 0, state -> IDLE.
REQ-021 bit_valid=1 in HOLD SHALL drop the bit and set overrun <= 1; start in HOLD is ignored.
REQ-022 overrun SHALL be sticky and cleared only by reset.
REQ-023 out_data SHALL change only on the completion edge or on reset, never while out_valid=1 and no transfer has occurred.
REQ-024 MSB_FIRST=1 SHALL shift left (new bit enters bit 0); MSB_FIRST=0 SHALL shift right (new bit enters bit WIDTH-1).

Reset
REQ-025 reset=1 at a rising edge SHALL force: state=IDLE, out_valid=0, out_data=0, busy=0, overrun=0, bit_count=0, shift register=0.
REQ-026 reset SHALL take priority over every other input in every state, including mid-SHIFT and HOLD.

Structure
REQ-027 The state encodings (IDLE=2'd0, SHIFT=2'd1, HOLD=2'd2) SHALL live in a shared include/package, serial_defs, which the bench also uses.
REQ-028 The shift datapath SHALL be a sub-module, shift_reg_sipo (Clk, reset, clr, shift_en, din, q[WIDTH-1:0], parameters WIDTH and MSB_FIRST), instantiated once.

Verification
REQ-029 MSB_FIRST=1, start, then bits 1,0,1,1,0,0,1,0 on consecutive cycles -> out_valid=1 with out_data=8'hB2 one cycle after the 8th bit; bit_count=8.
REQ-030 MSB_FIRST=0, same stream -> out_data=8'h4D.
REQ-031 Hold out_ready=0 for 5 cycles in HOLD while pulsing bit_valid -> out_data stays 8'hB2 and overrun=1; then out_ready=1 -> out_valid=0 next cycle, overrun stays 1.
REQ-032 start, 3 bits, start again, then 8 bits 0xA5 MSB-first with 2-cycle bit_valid gaps -> out_data=8'hA5.
REQ-033 reset asserted after 5 bits of a frame -> next cycle all outputs 0, state IDLE; bit_valid alone then has no effect.
REQ-034 start and bit_valid asserted in the same cycle in SHIFT -> that bit is discarded and bit_count=0.
